// File: rtl/ram_pkg.sv
// Shared constants and FSM state type for banked_ram.
// Optional sweep logic is enabled by defining BANKED_RAM_CLEAR_EN.
package ram_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned DEF_BANK_W = 3;

  typedef enum logic {
    READY = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/ram_bank.sv
// Single RAM bank: asynchronous read, synchronous write, no reset on contents.
module ram_bank #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OFF_W = 6
) (
  input  logic             CLK,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [OFF_W-1:0] address,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] r_mem [2**OFF_W];

  always_ff @(posedge CLK) begin
    if (load) r_mem[address] <= in;
  end

  assign out = r_mem[address];

endmodule

// File: rtl/banked_ram.sv
// Banked RAM with combinational read and an optional whole-memory clear sweep
// (compiled in when BANKED_RAM_CLEAR_EN is defined).
module banked_ram
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned BANK_W = DEF_BANK_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int unsigned OFF_W  = ADDR_W - BANK_W;
  localparam int unsigned NBANKS = 2**BANK_W;

  logic [BANK_W-1:0] w_bank_sel;
  logic [OFF_W-1:0]  w_off_in;
  logic [OFF_W-1:0]  w_off;
  logic [WIDTH-1:0]  w_wdata;
  logic              w_clearing;
  logic              w_load_ok;
  logic [WIDTH-1:0]  w_bank_out [NBANKS];

  assign w_bank_sel = address[ADDR_W-1 -: BANK_W];
  assign w_off_in   = address[OFF_W-1:0];

`ifdef BANKED_RAM_CLEAR_EN
  state_t           r_state;
  logic [OFF_W-1:0] r_cnt;
  logic             r_busy;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        READY: begin
          if (clear) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          // Counter wraps to 0 on the final offset.
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_state <= READY;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= READY;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_clearing = (r_state == CLEAR);
  // clear wins over a simultaneous load.
  assign w_load_ok  = load & ~clear;
  assign w_off      = w_clearing ? r_cnt : w_off_in;
  assign w_wdata    = w_clearing ? '0 : in;
  assign busy       = r_busy;
`else
  logic w_unused_ctrl;

  assign w_unused_ctrl = clear ^ RST_N;
  assign w_clearing    = 1'b0;
  assign w_load_ok     = load;
  assign w_off         = w_off_in;
  assign w_wdata       = in;
  assign busy          = 1'b0;
`endif

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic w_load_bank;

    assign w_load_bank = w_clearing | (w_load_ok & (w_bank_sel == BANK_W'(b)));

    ram_bank #(
      .WIDTH(WIDTH),
      .OFF_W(OFF_W)
    ) u_bank (
      .CLK    (CLK),
      .in     (w_wdata),
      .load   (w_load_bank),
      .address(w_off),
      .out    (w_bank_out[b])
    );
  end

  assign out = w_clearing ? '0 : w_bank_out[w_bank_sel];

endmodule

// File: tb/tb_banked_ram.sv
// Self-checking bench for banked_ram against a flat-array reference model;
// exercises the sweep paths when BANKED_RAM_CLEAR_EN is defined.
module tb_banked_ram;

  localparam int WIDTH = 16;
  localparam int ADDR_W = 9;
  localparam int DEPTH = 2**ADDR_W;
  localparam int SWEEP = 64;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [WIDTH-1:0]  in;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic              clear;
  logic [WIDTH-1:0]  out;
  logic              busy;

  logic [WIDTH-1:0] mem [DEPTH];
  int checks = 0;
  int errors = 0;

  banked_ram dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .in     (in),
    .load   (load),
    .address(address),
    .clear  (clear),
    .out    (out),
    .busy   (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write(input int a, input logic [WIDTH-1:0] d);
    address = ADDR_W'(a);
    in      = d;
    load    = 1'b1;
    tick();
    mem[a]  = d;
    load    = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      address = ADDR_W'(a);
      #1;
      check(tag, out, mem[a]);
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < DEPTH; a++) write(a, WIDTH'($urandom));
  endtask

`ifdef BANKED_RAM_CLEAR_EN
  // Expects busy high for exactly SWEEP samples, then low; out forced to 0 meanwhile.
  task automatic expect_sweep(input string tag, input int reclear_at);
    for (int k = 0; k < SWEEP; k++) begin
      clear   = (k == reclear_at);
      address = ADDR_W'($urandom);
      #1;
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_out0"}, out, '0);
      tick();
    end
    clear = 1'b0;
    check({tag, "_done"}, busy, 1'b0);
    for (int a = 0; a < DEPTH; a++) mem[a] = '0;
  endtask
`endif

  initial begin
    RST_N   = 1'b0;
    in      = '0;
    load    = 1'b0;
    address = '0;
    clear   = 1'b0;
    #12;
`ifdef BANKED_RAM_CLEAR_EN
    check("rst_busy", busy, 1'b1);
    check("rst_out", out, '0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    expect_sweep("init", -1);
    read_all("init_zero");
`else
    check("rst_busy", busy, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("post_rst_busy", busy, 1'b0);
    // Contents are undefined after reset, so establish known data first.
    fill_random();
    read_all("fill");
`endif

    write(12'h000, 16'h1234);
    write(12'h1C0, 16'h5678);
    address = 9'h000; #1; check("rd_000", out, 16'h1234);
    address = 9'h1C0; #1; check("rd_1C0", out, 16'h5678);
    address = 9'h040; #1; check("rd_040", out, mem[9'h040]);

    // Read-before-write
    address = 9'h0A5;
    in      = 16'hBEEF;
    load    = 1'b1;
    #1;
    check("rbw_before", out, mem[9'h0A5]);
    tick();
    mem[9'h0A5] = 16'hBEEF;
    load = 1'b0;
    check("rbw_after", out, 16'hBEEF);

    // Random reads and writes; full read-back catches cross-bank writes.
    for (int i = 0; i < 400; i++) begin
      int a;
      logic ld;
      logic [WIDTH-1:0] d;
      a       = int'($urandom_range(DEPTH - 1, 0));
      ld      = 1'($urandom);
      d       = WIDTH'($urandom);
      address = ADDR_W'(a);
      in      = d;
      load    = ld;
      #1;
      check("rand_rd", out, mem[a]);
      check("rand_busy", busy, 1'b0);
      tick();
      if (ld) mem[a] = d;
    end
    load = 1'b0;
    read_all("rand_final");

`ifdef BANKED_RAM_CLEAR_EN
    // clear with load in the same cycle, then load held through the sweep.
    fill_random();
    address = 9'h033;
    in      = 16'hAAAA;
    clear   = 1'b1;
    load    = 1'b1;
    tick();
    clear   = 1'b0;
    expect_sweep("clr_load", -1);
    load = 1'b0;
    read_all("clr_load_zero");

    // Re-pulsed clear mid-sweep must not extend it.
    fill_random();
    clear = 1'b1;
    tick();
    expect_sweep("reclr", 30);
    read_all("reclr_zero");

    // Reset mid-sweep restarts from offset 0.
    fill_random();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (20) tick();
    RST_N = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b1);
    check("midrst_out", out, '0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    expect_sweep("midrst", -1);
    read_all("midrst_zero");
`else
    // clear is ignored: busy stays low and a simultaneous write lands.
    address = 9'h155;
    in      = 16'hC0DE;
    load    = 1'b1;
    clear   = 1'b1;
    tick();
    mem[9'h155] = 16'hC0DE;
    load  = 1'b0;
    clear = 1'b0;
    check("clr_ign_busy", busy, 1'b0);
    check("clr_ign_data", out, 16'hC0DE);
    repeat (3) tick();
    check("clr_ign_idle", busy, 1'b0);
    read_all("clr_ign_all");

    // Reset leaves contents intact and the first write reads back next cycle.
    RST_N = 1'b0;
    #1;
    check("rst2_busy", busy, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    write(9'h1FF, 16'h7E57);
    check("rst2_wr", out, 16'h7E57);
    check("rst2_busy_after", busy, 1'b0);
    read_all("rst2_all");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
